// File: rtl/ps2_command_tx.sv
// ---------------------------------------------------------------------------
// ps2_command_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set
// LEDs, 0xFF reset) to the attached keyboard over the shared open-drain
// PS/2 clock and data pins. It performs the request-to-send sequence,
// shifts data, odd parity and stop on device-generated falling clock
// edges, and then checks the device line-ACK.
//
// Ports:
//   iClock      system clock, the only clock domain
//   iReset      asynchronous, active-high reset
//   iPS2_Clock  PS/2 clock pin, open-drain (driven 0 or Z only)
//   iPS2_Dat    PS/2 data pin, open-drain (driven 0 or Z only)
//   iCommand    byte to send, captured when iSend is accepted
//   iSend       one-cycle send request, ignored while oBusy is high
//   oBusy       transfer in progress (receive path should be gated off)
//   oDone       one-cycle pulse after a successful device ACK
//   oError      one-cycle pulse on timeout or missing ACK
//
// INHIBIT_CYCLES must be at least 2 so that the start bit can be placed
// on the final inhibit cycle.
// ---------------------------------------------------------------------------
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES     = 5000,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int FRAME_TIMEOUT      = 100000
) (
    input  logic       iClock,
    input  logic       iReset,
    inout  wire        iPS2_Clock,
    inout  wire        iPS2_Dat,
    input  logic [7:0] iCommand,
    input  logic       iSend,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int FE_W  = $clog2(FIRST_EDGE_TIMEOUT + 1);
    localparam int FR_W  = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PEN  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
    localparam logic [FE_W-1:0]  FE_LAST  = FE_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [FE_W-1:0]  FE_MAX   = FE_W'(FIRST_EDGE_TIMEOUT);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(FRAME_TIMEOUT - 1);
    localparam logic [FR_W-1:0]  FR_MAX   = FR_W'(FRAME_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        FAIL
    } state_t;

    state_t             state_q;
    logic [10:0]        shift_q;
    logic [INH_W-1:0]   inhCnt_q;
    logic [FE_W-1:0]    firstCnt_q;
    logic [FR_W-1:0]    frameCnt_q;
    logic [3:0]         bitCnt_q;
    logic               clkLow_q;
    logic               datLow_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic [1:0]         clkSync_q;
    logic [1:0]         datSync_q;
    logic               clkLast_q;

    logic               fallEdge;
    logic               linesIdle;
    logic               firstTimeout;
    logic               frameTimeout;
    logic               failReq_d;

    // Open-drain pin drivers: the registered "pull low" flags are cleared
    // by the asynchronous reset, so the pins float the moment reset rises.
    assign iPS2_Clock = clkLow_q ? 1'b0 : 1'bz;
    assign iPS2_Dat   = datLow_q ? 1'b0 : 1'bz;

    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oError = error_q;

    // Two-flop synchronizers for both pins plus a delayed copy of the
    // synced clock for falling-edge detection. They reset to 1 (idle bus)
    // so that leaving reset never looks like a falling edge.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
            clkLast_q <= 1'b1;
        end else begin
            clkSync_q <= {clkSync_q[0], iPS2_Clock};
            datSync_q <= {datSync_q[0], iPS2_Dat};
            clkLast_q <= clkSync_q[1];
        end
    end

    assign fallEdge     = clkLast_q & ~clkSync_q[1];
    assign linesIdle    = clkSync_q[1] & datSync_q[1];
    assign firstTimeout = (firstCnt_q >= FE_LAST);
    assign frameTimeout = (frameCnt_q >= FR_LAST);

    // Abort decision. A device edge always beats a timer that expires in
    // the same cycle, so in ACK the ACK sample decides the outcome.
    always_comb begin
        failReq_d = 1'b0;
        case (state_q)
            REQ:       failReq_d = ~fallEdge & firstTimeout;
            SHIFT:     failReq_d = ~fallEdge & frameTimeout;
            ACK:       failReq_d = fallEdge ? datSync_q[1] : frameTimeout;
            WAIT_IDLE: failReq_d = ~linesIdle & frameTimeout;
            default:   failReq_d = 1'b0;
        endcase
    end

    // Transfer sequencer. The shift register holds the whole frame
    // {stop, parity, data[7:0], start}; bit 0 is what is currently on the
    // data line and each device falling edge moves the next bit into it.
    // Pin drivers and the done/error pulses are all registered here.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            inhCnt_q   <= '0;
            firstCnt_q <= '0;
            frameCnt_q <= '0;
            bitCnt_q   <= '0;
            clkLow_q   <= 1'b0;
            datLow_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;

            if (state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
                if (frameCnt_q != FR_MAX) begin
                    frameCnt_q <= frameCnt_q + FR_W'(1);
                end
            end

            if (failReq_d) begin
                clkLow_q <= 1'b0;
                datLow_q <= 1'b0;
                busy_q   <= 1'b0;
                error_q  <= 1'b1;
                state_q  <= FAIL;
            end else begin
                case (state_q)
                    IDLE: begin
                        clkLow_q <= 1'b0;
                        datLow_q <= 1'b0;
                        if (iSend) begin
                            shift_q  <= {1'b1, ~^iCommand, iCommand, 1'b0};
                            inhCnt_q <= '0;
                            clkLow_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= INHIBIT;
                        end
                    end

                    // Hold the clock low; the start bit goes onto the data
                    // line for the last inhibit cycle.
                    INHIBIT: begin
                        if (inhCnt_q == INH_LAST) begin
                            clkLow_q   <= 1'b0;
                            firstCnt_q <= '0;
                            state_q    <= REQ;
                        end else begin
                            if (inhCnt_q == INH_PEN) begin
                                datLow_q <= ~shift_q[0];
                            end
                            if (inhCnt_q != INH_MAX) begin
                                inhCnt_q <= inhCnt_q + INH_W'(1);
                            end
                        end
                    end

                    // Clock released, start bit on the line; first device
                    // falling edge presents data bit 0 and starts the frame
                    // timer.
                    REQ: begin
                        if (fallEdge) begin
                            shift_q    <= {1'b1, shift_q[10:1]};
                            datLow_q   <= ~shift_q[1];
                            bitCnt_q   <= 4'd1;
                            frameCnt_q <= '0;
                            state_q    <= SHIFT;
                        end else if (firstCnt_q != FE_MAX) begin
                            firstCnt_q <= firstCnt_q + FE_W'(1);
                        end
                    end

                    // Edges 2..10 present bits 1..7, parity and stop.
                    SHIFT: begin
                        if (fallEdge) begin
                            shift_q  <= {1'b1, shift_q[10:1]};
                            datLow_q <= ~shift_q[1];
                            bitCnt_q <= bitCnt_q + 4'd1;
                            if (bitCnt_q == 4'd9) begin
                                state_q <= ACK;
                            end
                        end
                    end

                    // Stop bit leaves data released; a low sample at the
                    // 11th edge is the device ACK (high is handled above).
                    ACK: begin
                        datLow_q <= 1'b0;
                        if (fallEdge) begin
                            state_q <= WAIT_IDLE;
                        end
                    end

                    WAIT_IDLE: begin
                        if (linesIdle) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end

                    FAIL: begin
                        clkLow_q <= 1'b0;
                        datLow_q <= 1'b0;
                        state_q  <= IDLE;
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
